// File: rtl/unit3to1.sv
// Ternary-weight 3-in/1-out neuron: sign-of-weighted-sum forward path, error fan-out with
// vote-counter weight training, and serial weight readout while idle.
module unit3to1 #(
  parameter logic [5:0] WEIGHT_INIT = 6'b00_00_01,
  parameter int         CNT_W       = 4,
  parameter int         THRESH      = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic oscillator,
  input  logic fd_prop,
  input  logic bk_prop,
  input  logic fin0,
  input  logic fin1,
  input  logic fin2,
  input  logic bin,
  output logic fout,
  output logic bout0,
  output logic bout1,
  output logic bout2,
  output logic control_out,
  output logic control_sof
);

  // state  | meaning
  // S_IDLE | stream weights on control_out
  // S_FWD  | compute fout, capture inputs into x_q
  // S_BWD  | drive bout*, train weights from captured inputs
  typedef enum logic [1:0] {S_IDLE, S_FWD, S_BWD} state_t;

  localparam logic signed [CNT_W-1:0] THR_P = CNT_W'(THRESH);
  localparam logic signed [CNT_W-1:0] THR_N = -THR_P;
  localparam logic signed [CNT_W-1:0] ONE   = CNT_W'(1);

  state_t state_q, state_d;

  logic [2:0][1:0]       w_q, w_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            x_q, x_d;
  logic [2:0]            bout_q, bout_d;
  logic                  fout_q, fout_d;
  logic                  co_q, co_d;
  logic                  sof_q, sof_d;
  logic [2:0]            ptr_q, ptr_d;

  logic [2:0]                   fin_v;
  logic signed [2:0]            sum_s;
  logic [2:0]                   frame_ptr;
  logic signed [CNT_W-1:0]      cnt_sum [3];

  // Code 10 is illegal and counts as zero everywhere except the readout stream.
  function automatic logic signed [2:0] w_val(input logic [1:0] w);
    case (w)
      2'b01:   return 3'sd1;
      2'b11:   return -3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  function automatic logic [1:0] w_up(input logic [1:0] w);
    return (w == 2'b11) ? 2'b00 : 2'b01;
  endfunction

  function automatic logic [1:0] w_down(input logic [1:0] w);
    return (w == 2'b01) ? 2'b00 : 2'b11;
  endfunction

  assign fin_v = {fin2, fin1, fin0};
  // Any non-idle cycle restarts the readout frame at bit 0.
  assign frame_ptr = (state_q == S_IDLE) ? ptr_q : 3'd0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      w_q     <= WEIGHT_INIT;
      cnt_q   <= '0;
      x_q     <= '0;
      bout_q  <= '0;
      fout_q  <= 1'b0;
      co_q    <= 1'b0;
      sof_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      bout_q  <= bout_d;
      fout_q  <= fout_d;
      co_q    <= co_d;
      sof_q   <= sof_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    if (fd_prop)      state_d = S_FWD;
    else if (bk_prop) state_d = S_BWD;
  end

  always_comb begin
    sum_s = 3'sd0;
    for (int i = 0; i < 3; i++) begin
      sum_s = sum_s + (fin_v[i] ? w_val(w_q[i]) : -w_val(w_q[i]));
      cnt_sum[i] = $signed(cnt_q[i]) + ((bin == x_q[i]) ? ONE : -ONE);
    end
  end

  always_comb begin
    fout_d = fout_q;
    bout_d = bout_q;
    x_d    = x_q;
    w_d    = w_q;
    cnt_d  = cnt_q;
    co_d   = co_q;
    sof_d  = sof_q;
    ptr_d  = ptr_q;
    case (state_d)
      S_FWD: begin
        fout_d = (sum_s > 3'sd0) ? 1'b1 : (sum_s < 3'sd0) ? 1'b0 : oscillator;
        x_d    = fin_v;
        sof_d  = 1'b0;
      end
      S_BWD: begin
        sof_d = 1'b0;
        for (int i = 0; i < 3; i++) begin
          bout_d[i] = (w_val(w_q[i]) == 3'sd0) ? oscillator
                                                : (bin ~^ (w_val(w_q[i]) == 3'sd1));
          if (cnt_sum[i] == THR_P) begin
            w_d[i]   = w_up(w_q[i]);
            cnt_d[i] = '0;
          end else if (cnt_sum[i] == THR_N) begin
            w_d[i]   = w_down(w_q[i]);
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_sum[i];
          end
        end
      end
      default: begin
        co_d  = w_q[frame_ptr / 3'd2][frame_ptr[0]];
        sof_d = (frame_ptr == 3'd0);
        ptr_d = (frame_ptr == 3'd5) ? 3'd0 : frame_ptr + 3'd1;
      end
    endcase
  end

  assign fout        = fout_q;
  assign bout0       = bout_q[0];
  assign bout1       = bout_q[1];
  assign bout2       = bout_q[2];
  assign control_out = co_q;
  assign control_sof = sof_q;

endmodule

// File: tb/tb_unit3to1.sv
// Directed bench for unit3to1: stimulus pushes hand-computed expectations into a queue,
// a negedge monitor pops and compares them when they fall due.
module tb_unit3to1;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, osc = 1'b0, fd = 1'b0, bk = 1'b0, bin = 1'b0;
  logic [2:0] fin = 3'b000;
  logic fout, bout0, bout1, bout2, control_out, control_sof;

  unit3to1 #(.WEIGHT_INIT(6'b11_00_01), .CNT_W(4), .THRESH(4)) dut (
    .clk_in(clk), .rst_in(rst), .oscillator(osc), .fd_prop(fd), .bk_prop(bk),
    .fin0(fin[0]), .fin1(fin[1]), .fin2(fin[2]), .bin(bin),
    .fout(fout), .bout0(bout0), .bout1(bout1), .bout2(bout2),
    .control_out(control_out), .control_sof(control_sof)
  );

  localparam int FOUT = 0, B0 = 1, B1 = 2, B2 = 3, CO = 4, SOF = 5;

  typedef struct {
    int    due;
    int    sig;
    logic  val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  logic [5:0] obs;

  assign obs = {control_sof, control_out, bout2, bout1, bout0, fout};

  always @(posedge clk) cyc++;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        n_cmp++;
        if (e.due < cyc) begin
          n_bad++;
          $display("FAIL %s sig%0d: not checked at cycle %0d (now %0d)", e.name, e.sig, e.due, cyc);
        end else if (obs[e.sig] !== e.val) begin
          n_bad++;
          $display("FAIL %s sig%0d cyc%0d: got %b want %b", e.name, e.sig, cyc, obs[e.sig], e.val);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic b, input logic [2:0] fi,
                       input logic bi, input logic o);
    @(posedge clk);
    #2;
    rst = r; fd = f; bk = b; fin = fi; bin = bi; osc = o;
  endtask

  task automatic expect_o(input int sig, input logic v, input string nm);
    exp_t e;
    e.due = cyc + 1; e.sig = sig; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_b(input logic [2:0] v, input string nm);
    expect_o(B0, v[0], nm);
    expect_o(B1, v[1], nm);
    expect_o(B2, v[2], nm);
  endtask

  task automatic fwd(input logic [2:0] fi, input logic o, input logic want, input string nm);
    drive(1'b0, 1'b1, 1'b0, fi, 1'b0, o);
    expect_o(FOUT, want, nm);
  endtask

  task automatic bwd(input int n, input logic bi, input logic o, input logic [2:0] bv,
                     input logic fhold, input string nm);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b1, 3'b000, bi, o);
      exp_b(bv, nm);
      expect_o(FOUT, fhold, nm);
    end
  endtask

  task automatic idle_frame(input logic [5:0] wv, input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
      expect_o(CO, wv[i % 6], nm);
      expect_o(SOF, (i % 6) == 0, nm);
    end
  endtask

  initial begin
    // reset: every output cleared
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);
    for (int s = 0; s < 6; s++) expect_o(s, 1'b0, "reset");

    // readout of initial weights {w2,w1,w0} = -1,0,+1
    idle_frame(6'b110001, 12, "idle_init");
    idle_frame(6'b110001, 2, "idle_part");
    // fd pulse mid-frame: tie resolved by oscillator, stream holds, sof low
    fwd(3'b111, 1'b1, 1'b1, "tie_osc1");
    expect_o(CO, 1'b0, "co_hold");
    expect_o(SOF, 1'b0, "sof_fwd");
    fwd(3'b111, 1'b0, 1'b0, "tie_osc0");
    fwd(3'b110, 1'b1, 1'b0, "neg_ignores_osc");
    idle_frame(6'b110001, 6, "idle_restart");

    // training round 1: all votes +1; w1 0->+1, w2 -1->0, w0 saturates
    fwd(3'b111, 1'b1, 1'b1, "r1_fwd");
    bwd(4, 1'b1, 1'b0, 3'b001, 1'b1, "r1_bwd");
    idle_frame(6'b000101, 6, "r1_weights");

    // round 2: w2 0->+1
    fwd(3'b111, 1'b0, 1'b1, "r2_fwd");
    bwd(4, 1'b1, 1'b1, 3'b111, 1'b1, "r2_bwd");
    idle_frame(6'b010101, 6, "r2_weights");

    // all weights +1
    fwd(3'b011, 1'b0, 1'b1, "w111_s+1");
    fwd(3'b001, 1'b0, 1'b0, "w111_s-1");
    fwd(3'b000, 1'b1, 1'b0, "w111_s-3");
    fwd(3'b111, 1'b0, 1'b1, "w111_s+3");
    fwd(3'b110, 1'b0, 1'b1, "w111_s+1b");

    // round 3: x=001, bin=1 -> w1,w2 step down to 0
    fwd(3'b001, 1'b1, 1'b0, "r3_fwd");
    bwd(4, 1'b1, 1'b0, 3'b111, 1'b0, "r3_bwd");

    // round 4: w1 votes down 4 times, w2 votes cancel out
    fwd(3'b101, 1'b0, 1'b1, "r4_fwd_a");
    bwd(2, 1'b1, 1'b0, 3'b001, 1'b1, "r4_bwd_a");
    fwd(3'b001, 1'b0, 1'b1, "r4_fwd_b");
    bwd(2, 1'b1, 1'b0, 3'b001, 1'b1, "r4_bwd_b");
    idle_frame(6'b001101, 6, "r4_weights");

    // error fan-out with w0=+1, w1=-1, w2=0
    bwd(1, 1'b1, 1'b0, 3'b001, 1'b1, "bout_bin1");
    bwd(1, 1'b0, 1'b1, 3'b110, 1'b1, "bout_bin0");
    fwd(3'b100, 1'b1, 1'b1, "r4_tie");
    fwd(3'b010, 1'b1, 1'b0, "r4_s-2");

    // reset during BWD with counters at 3
    fwd(3'b111, 1'b1, 1'b1, "pre_rst_fwd");
    bwd(3, 1'b1, 1'b0, 3'b001, 1'b1, "pre_rst_bwd");
    drive(1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b1);
    for (int s = 0; s < 6; s++) expect_o(s, 1'b0, "rst_mid");
    idle_frame(6'b110001, 6, "rst_weights");
    // counters cleared: four -1 votes step w0 down and w1 down
    fwd(3'b111, 1'b1, 1'b1, "post_rst_fwd");
    bwd(4, 1'b0, 1'b0, 3'b100, 1'b1, "post_rst_bwd");
    idle_frame(6'b111100, 6, "post_rst_weights");
    fwd(3'b111, 1'b1, 1'b0, "post_rst_s-2");
    // fd_prop wins when both enables are high
    drive(1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    expect_o(FOUT, 1'b1, "fd_priority");
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
      n_cmp += sb.size();
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
